ray_frame_dispatcher: RTL

Frame-level issuer and collector for the ray generator. It walks the display raster one pixel at a time and hands each pixel's coordinates, normalised screen position and the frame's camera forward vector to the ray generator over its valid/ready handshake. It then captures the returned ray direction and presents it, tagged with its pixel coordinates, to the downstream ray marcher. Only one request is ever outstanding, which matches the generator's single-request behaviour.

---
 rtl/ray_frame_dispatcher.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ray_frame_dispatcher.sv
// ray_frame_dispatcher
// Walks the display raster one pixel at a time, issues each pixel (integer and
// fixed-point coordinates plus the frame's camera forward vector) to the ray
// generator, waits for its single outstanding result, and hands the tagged ray
// direction to the downstream ray marcher.
// Optional feature macro: RAY_DISPATCH_PERF_EN adds frame_cycles_out, a
// saturating count of busy cycles for the current/last frame.
`timescale 1ns/1ps

`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 180
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif
`ifndef NUM_FRAC_DIGITS
`define NUM_FRAC_DIGITS 16
`endif
`ifndef NUM_ALL_DIGITS
`define NUM_ALL_DIGITS 32
`endif

module ray_frame_dispatcher #(
   parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
   parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
   parameter int H_BITS         = `H_BITS,
   parameter int V_BITS         = `V_BITS
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            start_in,
   input  logic [3*`NUM_ALL_DIGITS-1:0]    cam_forward_in,
   output logic                            busy_out,
   output logic                            frame_done_out,
   output logic                            gen_valid_out,
   input  logic                            gen_ready_in,
   output logic [H_BITS-1:0]               gen_hcount_out,
   output logic [V_BITS-1:0]               gen_vcount_out,
   output logic [`NUM_ALL_DIGITS-1:0]      gen_hcount_fp_out,
   output logic [`NUM_ALL_DIGITS-1:0]      gen_vcount_fp_out,
   output logic [3*`NUM_ALL_DIGITS-1:0]    gen_cam_forward_out,
   input  logic                            gen_valid_in,
   input  logic [3*`NUM_ALL_DIGITS-1:0]    gen_ray_direction_in,
   output logic                            ray_valid_out,
   input  logic                            ray_ready_in,
   output logic [H_BITS-1:0]               ray_hcount_out,
   output logic [V_BITS-1:0]               ray_vcount_out,
`ifdef RAY_DISPATCH_PERF_EN
   output logic [31:0]                     frame_cycles_out,
`endif
   output logic [3*`NUM_ALL_DIGITS-1:0]    ray_direction_out
);

   localparam int F        = `NUM_FRAC_DIGITS;
   localparam int FP_BITS  = `NUM_ALL_DIGITS;
   localparam int VEC_BITS = 3 * FP_BITS;

   // Screen mapping px=(2h-W)/H, py=(2v-H)/H, stepped incrementally.
   localparam longint PX_STEP_I  = (longint'(2) << F) / DISPLAY_HEIGHT;
   localparam longint PX_START_I = -((longint'(DISPLAY_WIDTH) << F) / DISPLAY_HEIGHT);
   localparam longint PY_START_I = -(longint'(1) << F);

   localparam logic [FP_BITS-1:0] PX_STEP  = FP_BITS'(PX_STEP_I);
   localparam logic [FP_BITS-1:0] PY_STEP  = FP_BITS'(PX_STEP_I);
   localparam logic [FP_BITS-1:0] PX_START = FP_BITS'(PX_START_I);
   localparam logic [FP_BITS-1:0] PY_START = FP_BITS'(PY_START_I);

   localparam logic [H_BITS-1:0] H_LAST = H_BITS'(DISPLAY_WIDTH - 1);
   localparam logic [V_BITS-1:0] V_LAST = V_BITS'(DISPLAY_HEIGHT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DELIVER
   } state_t;

   // Two's-complement fixed-point add; wraps like the rest of the fp datapath.
   function automatic logic [FP_BITS-1:0] fp_add(input logic [FP_BITS-1:0] a,
                                                 input logic [FP_BITS-1:0] b);
      return a + b;
   endfunction

   state_t                state_q, state_d;
   logic [H_BITS-1:0]     h_q, h_d;
   logic [V_BITS-1:0]     v_q, v_d;
   logic [FP_BITS-1:0]    px_q, px_d;
   logic [FP_BITS-1:0]    py_q, py_d;
   logic [VEC_BITS-1:0]   fwd_q, fwd_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  ray_valid_q, ray_valid_d;
   logic [H_BITS-1:0]     ray_h_q, ray_h_d;
   logic [V_BITS-1:0]     ray_v_q, ray_v_d;
   logic [VEC_BITS-1:0]   ray_dir_q, ray_dir_d;
   logic                  gen_valid;
   logic                  last_pixel;

   assign last_pixel = (h_q == H_LAST) && (v_q == V_LAST);

   // Next-state and handshake decode for the issue/wait/deliver loop.
   always_comb begin
      // NOTE: every signal gets its default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      h_d         = h_q;
      v_d         = v_q;
      px_d        = px_q;
      py_d        = py_q;
      fwd_d       = fwd_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      ray_valid_d = ray_valid_q;
      ray_h_d     = ray_h_q;
      ray_v_d     = ray_v_q;
      ray_dir_d   = ray_dir_q;
      gen_valid   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               fwd_d   = cam_forward_in;
               h_d     = '0;
               v_d     = '0;
               px_d    = PX_START;
               py_d    = PY_START;
               busy_d  = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (gen_ready_in) begin
               gen_valid = 1'b1;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (gen_valid_in) begin
               ray_dir_d   = gen_ray_direction_in;
               ray_h_d     = h_q;
               ray_v_d     = v_q;
               ray_valid_d = 1'b1;
               state_d     = S_DELIVER;
            end
         end
         S_DELIVER: begin
            if (ray_ready_in) begin
               ray_valid_d = 1'b0;
               if (last_pixel) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  if (h_q != H_LAST) begin
                     h_d  = h_q + H_BITS'(1);
                     px_d = fp_add(px_q, PX_STEP);
                  end else begin
                     // Row wrap reloads px from the constant: no drift between rows.
                     h_d  = '0;
                     px_d = PX_START;
                     v_d  = v_q + V_BITS'(1);
                     py_d = fp_add(py_q, PY_STEP);
                  end
                  state_d = S_ISSUE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= S_IDLE;
         h_q         <= '0;
         v_q         <= '0;
         px_q        <= '0;
         py_q        <= '0;
         fwd_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ray_valid_q <= 1'b0;
         ray_h_q     <= '0;
         ray_v_q     <= '0;
         ray_dir_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q     <= state_d;
         h_q         <= h_d;
         v_q         <= v_d;
         px_q        <= px_d;
         py_q        <= py_d;
         fwd_q       <= fwd_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ray_valid_q <= ray_valid_d;
         ray_h_q     <= ray_h_d;
         ray_v_q     <= ray_v_d;
         ray_dir_q   <= ray_dir_d;
      end
   end

   assign busy_out            = busy_q;
   assign frame_done_out      = done_q;
   assign gen_valid_out       = gen_valid;
   assign gen_hcount_out      = h_q;
   assign gen_vcount_out      = v_q;
   assign gen_hcount_fp_out   = px_q;
   assign gen_vcount_fp_out   = py_q;
   assign gen_cam_forward_out = fwd_q;
   assign ray_valid_out       = ray_valid_q;
   assign ray_hcount_out      = ray_h_q;
   assign ray_vcount_out      = ray_v_q;
   assign ray_direction_out   = ray_dir_q;

`ifdef RAY_DISPATCH_PERF_EN
   logic [31:0] cyc_q, cyc_d;

   // Busy-cycle counter: cleared on frame start, saturating, held after done.
   always_comb begin
      cyc_d = cyc_q;
      if (state_q == S_IDLE && start_in) begin
         cyc_d = '0;
      end else if (busy_q && cyc_q != 32'hFFFF_FFFF) begin
         cyc_d = cyc_q + 32'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cyc_q <= '0;
      end else begin
         cyc_q <= cyc_d;
      end
   end

   assign frame_cycles_out = cyc_q;
`endif

endmodule
